rv32v_uop_sequencer: RTL and testbench
======================================

# rv32v_uop_sequencer

Sequences one vector instruction into a stream of micro-ops that drive the rv32v mask unit and the 4-lane datapath. For each accepted instruction it produces `uop_num`, `lane_active`, segment field index and control flags with a valid/ready handshake toward the lanes. It sits between vector decode/issue and the mask unit / lane execute stage.

## Interface
- Parameters
  - `NUM_LANES`, 4: lanes per uop. The design supports only 4, matching the 128-bit v0 indexing.
  - `SEG_MAX_ELEMS`, 32: maximum elements issued for a segment op.
- Ports
  - `CLK` in 1: clock.
  - `nRST` in 1: reset, synchronous, active-low.
  - `start` in 1: instruction valid from issue.
  - `start_ready` out 1: sequencer idle, can accept `start`.
  - `vl` in 8: vector length in elements, 0..128.
  - `is_seg_op` in 1: segment load/store.
  - `nfields` in 3: segment fields minus 1 (0..7). Used only when `is_seg_op`.
  - `mask_enable_in` in 1: vm=0, masked instruction.
  - `flush` in 1: squash the current instruction.
  - `uop_valid` out 1: uop outputs valid.
  - `uop_ready` in 1: lane stage accepts the uop.
  - `uop_num` out 5: non-seg: uop index; seg: element index.
  - `lane_active` out 4: non-seg: per-lane active bitmap; seg: `{2'b00, elem[1:0]}` lane encoding.
  - `field_idx` out 3: segment field of the current uop; 0 for non-seg.
  - `is_seg_op_out`, `mask_enable_out` out 1 each: latched instruction flags for the mask unit.
  - `last_uop` out 1: current uop is the final one.
  - `done` out 1: one-cycle pulse after the final handshake.

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE
  - `start_ready`=1.
  - On `start`, latch `vl`, `is_seg_op`, `nfields` and `mask_enable_in`.
    - If the effective length is 0, go to DONE.
    - Otherwise go to ISSUE with counters cleared.
- Effective length
  - Non-seg: `vl`.
  - Seg: min(`vl`, 32).
- Non-seg issue
  - `num_uops` = ceil(vl/4), range 1..32.
  - For uop i, `lane_active[k]` = (4i+k < vl).
  - `last_uop` = (i == num_uops-1).
- Seg issue
  - One uop per (element, field).
  - Order is element-major, field-minor: e0f0, e0f1 … e0fN, e1f0 ….
  - `uop_num` = element, `field_idx` = field, `lane_active` = `{2'b00, element[1:0]}`.
  - `last_uop` = (element == eff_len-1 && field == nfields).
- ISSUE
  - `uop_valid`=1.
  - Outputs hold stable while `uop_valid && !uop_ready`.
  - On handshake, advance to the next uop; on handshake of the last uop, go to DONE.
- DONE: `done`=1 for exactly one cycle, `uop_valid`=0, then IDLE.
- `flush`
  - In any state, the next state is IDLE.
  - `uop_valid` and `done` are 0 next cycle; `done` is not pulsed.
  - `flush` has priority over a same-cycle handshake and over `start`.
- `start` is ignored when not in IDLE.
- Counter arithmetic
  - Element counter: 6 bits, so eff_len 32 needs no wrap.
  - Uop counter: 5 bits.
  - `vl` > 128 is undefined input; the sequencer takes the low 8 bits as given.

## Timing
- Reset (`nRST`=0 at a CLK edge):
  - state = IDLE.
  - All outputs 0 except `start_ready`=1.
  - Latched flags cleared.
- All outputs are registered.
- Latency and throughput:
  - `start` accepted at edge T gives the first `uop_valid` at T+1.
  - With `uop_ready` held high, one uop per cycle.
  - `done` is asserted the cycle after the last handshake.
  - `start_ready` returns the cycle after `done`.
  - Non-seg instruction with vl=V and `uop_ready` always 1: `start` to `done` = ceil(V/4)+1 cycles.
- vl=0: `done` at T+1, no `uop_valid` ever.
- Reset mid-instruction: identical to `flush`, plus the latched flags are cleared.

## Test plan
- vl=10, non-seg, unmasked, `uop_ready`=1.
  - Three uops with `uop_num` 0,1,2 and `lane_active` 1111, 1111, 0011.
  - `last_uop` on uop 2; `done` one cycle later.
- vl=6, seg, nfields=2 (3 fields), masked.
  - 18 uops in order (e0,f0..2) … (e5,f0..2).
  - `lane_active` cycles 0,1,2,3,0,1 per element.
  - `mask_enable_out`=1 throughout.
- Backpressure: vl=8, `uop_ready` low for 3 cycles on uop 1.
  - `uop_num`=1 and `lane_active`=1111 held stable.
  - Advances only on handshake.
- Edge lengths:
  - vl=0 gives `done` at T+1 with no valid.
  - vl=128 gives 32 uops, last `uop_num`=31, `lane_active`=1111.
  - Seg vl=40, nfields=0 gives exactly 32 uops.
- Flush: during uop 3 of vl=64, assert `flush` with `uop_ready`=1.
  - Next cycle IDLE, `uop_valid`=0, no `done`.
  - A new `start` is accepted immediately.
- Reset: `nRST`=0 mid-ISSUE gives all outputs 0 and `start_ready`=1 at the next edge; `start` during ISSUE is ignored.

Source files
------------

// File: rtl/rv32v_uop_sequencer.sv
// Vector uop sequencer: expands one vector instruction into per-lane or
// per-(element,field) micro-ops for the mask unit and the 4-lane datapath.
module rv32v_uop_sequencer #(
  parameter int NUM_LANES     = 4,
  parameter int SEG_MAX_ELEMS = 32
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       start,
  output logic       start_ready,
  input  logic [7:0] vl,
  input  logic       is_seg_op,
  input  logic [2:0] nfields,
  input  logic       mask_enable_in,
  input  logic       flush,
  output logic       uop_valid,
  input  logic       uop_ready,
  output logic [4:0] uop_num,
  output logic [3:0] lane_active,
  output logic [2:0] field_idx,
  output logic       is_seg_op_out,
  output logic       mask_enable_out,
  output logic       last_uop,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] vl_q, vl_d;
  logic       seg_q, seg_d;
  logic [2:0] nf_q, nf_d;
  logic       mask_q, mask_d;
  logic [5:0] elem_q, elem_d;
  logic [2:0] field_q, field_d;
  logic [4:0] uop_q, uop_d;

  logic [7:0] start_len;
  logic [7:0] seg_len;
  logic [3:0] lane_ns;
  logic       last_ns;
  logic       last_seg;
  logic       last;
  logic       issue;

  // Segment ops clamp their element count; plain ops use vl as given.
  function automatic logic [7:0] eff_len(
    input logic [7:0] v,
    input logic       s
  );
    logic [7:0] cap;
    cap = 8'(SEG_MAX_ELEMS);
    if (s && (v > cap)) return cap;
    return v;
  endfunction

  assign start_len = eff_len(vl, is_seg_op);
  assign seg_len   = eff_len(vl_q, 1'b1);

  always_comb begin
    lane_ns = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_ns[k] = (9'(uop_q) * 9'(NUM_LANES) + 9'(k))
                   < {1'b0, vl_q};
    end
  end

  assign last_ns  = ((9'(uop_q) + 9'd1) * 9'(NUM_LANES))
                    >= {1'b0, vl_q};
  assign last_seg = ({2'b00, elem_q} == (seg_len - 8'd1))
                    && (field_q == nf_q);
  assign last     = seg_q ? last_seg : last_ns;
  assign issue    = (state_q == ISSUE);

  always_comb begin
    state_d = state_q;
    vl_d    = vl_q;
    seg_d   = seg_q;
    nf_d    = nf_q;
    mask_d  = mask_q;
    elem_d  = elem_q;
    field_d = field_q;
    uop_d   = uop_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          vl_d    = vl;
          seg_d   = is_seg_op;
          nf_d    = nfields;
          mask_d  = mask_enable_in;
          elem_d  = '0;
          field_d = '0;
          uop_d   = '0;
          state_d = (start_len == 8'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (uop_ready) begin
          if (last) begin
            state_d = DONE;
          end else if (seg_q) begin
            if (field_q == nf_q) begin
              field_d = '0;
              elem_d  = elem_q + 6'd1;
            end else begin
              field_d = field_q + 3'd1;
            end
          end else begin
            uop_d = uop_q + 5'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      elem_d  = '0;
      field_d = '0;
      uop_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      vl_q    <= '0;
      seg_q   <= 1'b0;
      nf_q    <= '0;
      mask_q  <= 1'b0;
      elem_q  <= '0;
      field_q <= '0;
      uop_q   <= '0;
    end else begin
      state_q <= state_d;
      vl_q    <= vl_d;
      seg_q   <= seg_d;
      nf_q    <= nf_d;
      mask_q  <= mask_d;
      elem_q  <= elem_d;
      field_q <= field_d;
      uop_q   <= uop_d;
    end
  end

  assign start_ready     = (state_q == IDLE);
  assign uop_valid       = issue;
  assign done            = (state_q == DONE);
  assign is_seg_op_out   = seg_q;
  assign mask_enable_out = mask_q;
  assign uop_num     = !issue ? 5'd0
                     : (seg_q ? elem_q[4:0] : uop_q);
  assign lane_active = !issue ? 4'd0
                     : (seg_q ? {2'b00, elem_q[1:0]} : lane_ns);
  assign field_idx   = (issue && seg_q) ? field_q : 3'd0;
  assign last_uop    = issue && last;

endmodule

// File: tb/tb_rv32v_uop_sequencer.sv
// Directed scoreboard bench for rv32v_uop_sequencer.
// Expected uops are queued at start and popped on each handshake.
module tb_rv32v_uop_sequencer;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       start;
  logic       start_ready;
  logic [7:0] vl;
  logic       is_seg_op;
  logic [2:0] nfields;
  logic       mask_enable_in;
  logic       flush;
  logic       uop_valid;
  logic       uop_ready;
  logic [4:0] uop_num;
  logic [3:0] lane_active;
  logic [2:0] field_idx;
  logic       is_seg_op_out;
  logic       mask_enable_out;
  logic       last_uop;
  logic       done;

  typedef struct packed {
    logic [4:0] num;
    logic [3:0] lane;
    logic [2:0] fld;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  rv32v_uop_sequencer dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .start           (start),
    .start_ready     (start_ready),
    .vl              (vl),
    .is_seg_op       (is_seg_op),
    .nfields         (nfields),
    .mask_enable_in  (mask_enable_in),
    .flush           (flush),
    .uop_valid       (uop_valid),
    .uop_ready       (uop_ready),
    .uop_num         (uop_num),
    .lane_active     (lane_active),
    .field_idx       (field_idx),
    .is_seg_op_out   (is_seg_op_out),
    .mask_enable_out (mask_enable_out),
    .last_uop        (last_uop),
    .done            (done)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [7:0] v, input bit s,
                     input logic [2:0] nf, input bit m,
                     input int stall_idx, input int stall_n);
    exp_t e;
    int   eff, n, total, popped, left, cyc;
    bit   got;
    q.delete();
    if (s) begin
      eff = (v > 8'd32) ? 32 : int'(v);
      for (int el = 0; el < eff; el++)
        for (int f = 0; f <= int'(nf); f++) begin
          e.num  = 5'(el);
          e.lane = 4'(el % 4);
          e.fld  = 3'(f);
          e.last = (el == eff - 1) && (f == int'(nf));
          q.push_back(e);
        end
    end else begin
      n = (int'(v) + 3) / 4;
      for (int i = 0; i < n; i++) begin
        e.num = 5'(i);
        for (int k = 0; k < 4; k++)
          e.lane[k] = (4 * i + k) < int'(v);
        e.fld  = 3'd0;
        e.last = (i == n - 1);
        q.push_back(e);
      end
    end
    total = q.size();
    vl = v;
    is_seg_op = s;
    nfields = nf;
    mask_enable_in = m;
    uop_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("first_out", (total > 0) ? uop_valid : done, 1);
    popped = 0;
    left = stall_n;
    cyc = 1;
    got = 0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        got = 1;
        break;
      end
      uop_ready = !(popped == stall_idx && left > 0);
      if (uop_valid) begin
        if (q.size() == 0) begin
          chk("extra_uop", uop_valid, 0);
        end else if (!uop_ready) begin
          left--;
          chk("hold_num", uop_num, q[0].num);
          chk("hold_lane", lane_active, q[0].lane);
        end else begin
          e = q.pop_front();
          chk("uop_num", uop_num, e.num);
          chk("lane_active", lane_active, e.lane);
          chk("field_idx", field_idx, e.fld);
          chk("last_uop", last_uop, e.last);
          chk("mask_out", mask_enable_out, m);
          chk("seg_out", is_seg_op_out, s);
          popped++;
        end
      end
      tick;
      cyc++;
    end
    uop_ready = 1'b1;
    chk("done_seen", got, 1);
    chk("all_popped", q.size(), 0);
    chk("latency", cyc, total + 1 + stall_n);
    tick;
    chk("done_once", done, 0);
    chk("ready_back", start_ready, 1);
  endtask

  initial begin
    nRST = 1'b0;
    start = 1'b0;
    vl = '0;
    is_seg_op = 1'b0;
    nfields = '0;
    mask_enable_in = 1'b0;
    flush = 1'b0;
    uop_ready = 1'b1;
    tick;
    tick;
    chk("rst_ready", start_ready, 1);
    chk("rst_valid", uop_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_num", uop_num, 0);
    chk("rst_lane", lane_active, 0);
    chk("rst_flags", {is_seg_op_out, mask_enable_out, last_uop}, 0);
    nRST = 1'b1;
    tick;

    run(8'd10, 1'b0, 3'd0, 1'b0, -1, 0);
    run(8'd6, 1'b1, 3'd2, 1'b1, -1, 0);
    run(8'd8, 1'b0, 3'd0, 1'b0, 1, 3);
    run(8'd0, 1'b0, 3'd0, 1'b0, -1, 0);
    run(8'd128, 1'b0, 3'd0, 1'b1, -1, 0);
    run(8'd40, 1'b1, 3'd0, 1'b0, -1, 0);
    run(8'd3, 1'b1, 3'd7, 1'b0, 2, 2);

    // Flush on uop 3 with a same-cycle handshake.
    vl = 8'd64;
    is_seg_op = 1'b0;
    mask_enable_in = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (uop_num == 5'd3) break;
      tick;
    end
    chk("flush_at3", uop_num, 3);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_valid", uop_valid, 0);
    chk("flush_done", done, 0);
    chk("flush_ready", start_ready, 1);
    run(8'd5, 1'b0, 3'd0, 1'b1, -1, 0);

    // Start during issue is ignored; reset mid-issue.
    vl = 8'd64;
    mask_enable_in = 1'b1;
    is_seg_op = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("pre_num", uop_num, 2);
    vl = 8'd4;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("ign_start", uop_num, 3);
    chk("ign_ready", start_ready, 0);
    nRST = 1'b0;
    tick;
    nRST = 1'b1;
    chk("mrst_valid", uop_valid, 0);
    chk("mrst_done", done, 0);
    chk("mrst_ready", start_ready, 1);
    chk("mrst_num", uop_num, 0);
    chk("mrst_lane", lane_active, 0);
    chk("mrst_mask", mask_enable_out, 0);
    chk("mrst_last", last_uop, 0);
    tick;
    chk("mrst_nodone", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
